// File: rtl/baud_tick_gen.sv
// Baud-rate timebase: one-cycle os_tick / bit_tick enables with four selectable rates.
// Define BAUD_FRAC_EN to enable the fractional-N accumulator (default build: integer divisors).
module baud_tick_gen #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned BAUD0      = 9600,
  parameter int unsigned BAUD1      = 19200,
  parameter int unsigned BAUD2      = 57600,
  parameter int unsigned BAUD3      = 115200,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4,
  localparam int unsigned PH_W      = $clog2(OVERSAMPLE)
) (
  input  logic            clk50MHz,
  input  logic            rst_n,
  input  logic            en,
  input  logic            sync,
  input  logic [1:0]      baud_sel,
  output logic            os_tick,
  output logic            bit_tick,
  output logic [PH_W-1:0] os_phase,
  output logic [1:0]      active_sel,
  output logic            sel_ack
);

`ifdef BAUD_FRAC_EN
  localparam int unsigned FracBits = FRAC_W;
`else
  localparam int unsigned FracBits = 0;
`endif

  function automatic longint unsigned calc_div(input longint unsigned baud);
    longint unsigned den;
    longint unsigned num;
    den = baud * longint'(OVERSAMPLE);
    num = longint'(CLK_HZ) << FracBits;
    return (num + den / 64'd2) / den;
  endfunction

  localparam longint unsigned Div0     = calc_div(longint'(BAUD0));
  localparam longint unsigned Div1     = calc_div(longint'(BAUD1));
  localparam longint unsigned Div2     = calc_div(longint'(BAUD2));
  localparam longint unsigned Div3     = calc_div(longint'(BAUD3));
  localparam longint unsigned Int0     = Div0 >> FracBits;
  localparam longint unsigned Int1     = Div1 >> FracBits;
  localparam longint unsigned Int2     = Div2 >> FracBits;
  localparam longint unsigned Int3     = Div3 >> FracBits;
  localparam longint unsigned IntLimit = 64'd1 << DIV_W;

  if (Int0 < 64'd2 || Int1 < 64'd2 || Int2 < 64'd2 || Int3 < 64'd2 ||
      Int0 >= IntLimit || Int1 >= IntLimit || Int2 >= IntLimit || Int3 >= IntLimit ||
      OVERSAMPLE < 4 || OVERSAMPLE > 32 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0 ||
      FRAC_W < 1) begin : g_bad_cfg
    $error("baud_tick_gen: invalid divisor configuration");
  end

  logic              r_run;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_tc;
  logic [PH_W-1:0]   r_os_phase;
  logic [1:0]        r_active_sel;
  logic              r_os_tick;
  logic              r_bit_tick;
  logic              r_sel_ack;

  logic              w_pending;
  logic              w_at_tc;
  logic              w_phase_wrap;
  logic              w_start;
  logic              w_apply;
  logic              w_keep_acc;
  logic              w_run_d;
  logic [DIV_W-1:0]  w_cnt_d;
  logic [DIV_W-1:0]  w_tc_d;
  logic [PH_W-1:0]   w_phase_d;
  logic              w_os_tick_d;
  logic              w_bit_tick_d;
  logic [1:0]        w_sel_n;
  logic [DIV_W-1:0]  w_int;

  always_comb begin
    // Reverting baud_sel drops the pending change without an ack.
    w_pending    = (baud_sel != r_active_sel) && !r_sel_ack;
    w_at_tc      = (r_cnt == r_tc);
    w_phase_wrap = (r_os_phase == PH_W'(OVERSAMPLE - 1));
    w_start      = 1'b0;
    w_apply      = 1'b0;
    w_keep_acc   = 1'b0;
    w_run_d      = r_run;
    w_cnt_d      = r_cnt;
    w_phase_d    = r_os_phase;
    w_os_tick_d  = 1'b0;
    w_bit_tick_d = 1'b0;
    if (!en) begin
      w_run_d   = 1'b0;
      w_cnt_d   = '0;
      w_phase_d = '0;
      w_apply   = w_pending;
    end else if (sync) begin
      w_run_d   = 1'b1;
      w_start   = 1'b1;
      w_cnt_d   = '0;
      w_phase_d = '0;
      w_apply   = w_pending;
    end else if (!r_run) begin
      w_run_d   = 1'b1;
      w_start   = 1'b1;
      w_cnt_d   = '0;
      w_phase_d = '0;
    end else if (w_at_tc) begin
      w_start      = 1'b1;
      w_cnt_d      = '0;
      w_os_tick_d  = 1'b1;
      w_bit_tick_d = w_phase_wrap;
      w_phase_d    = r_os_phase + 1'b1;
      w_apply      = w_pending && w_phase_wrap;
      w_keep_acc   = !w_apply;
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end
    w_sel_n = w_apply ? baud_sel : r_active_sel;
  end

  always_comb begin
    unique case (w_sel_n)
      2'd0:    w_int = DIV_W'(Int0);
      2'd1:    w_int = DIV_W'(Int1);
      2'd2:    w_int = DIV_W'(Int2);
      default: w_int = DIV_W'(Int3);
    endcase
  end

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] r_acc;
  logic [FRAC_W-1:0] w_acc_d;
  logic [FRAC_W-1:0] w_acc_base;
  logic [FRAC_W-1:0] w_acc_sum;
  logic [FRAC_W-1:0] w_frac;
  logic              w_carry;

  always_comb begin
    unique case (w_sel_n)
      2'd0:    w_frac = FRAC_W'(Div0);
      2'd1:    w_frac = FRAC_W'(Div1);
      2'd2:    w_frac = FRAC_W'(Div2);
      default: w_frac = FRAC_W'(Div3);
    endcase
  end

  always_comb begin
    // Fresh intervals (enable, sync, rate apply) restart the accumulator from zero.
    w_acc_base           = w_keep_acc ? r_acc : '0;
    {w_carry, w_acc_sum} = {1'b0, w_acc_base} + {1'b0, w_frac};
    w_acc_d              = en ? r_acc : '0;
    w_tc_d               = r_tc;
    if (w_start) begin
      w_acc_d = w_acc_sum;
      w_tc_d  = w_int - DIV_W'(1) + DIV_W'(w_carry);
    end
  end

  always_ff @(posedge clk50MHz) begin
    if (!rst_n) r_acc <= '0;
    else        r_acc <= w_acc_d;
  end
`else
  always_comb begin
    w_tc_d = r_tc;
    if (w_start) w_tc_d = w_int - DIV_W'(1);
  end
`endif

  always_ff @(posedge clk50MHz) begin
    if (!rst_n) begin
      r_run        <= 1'b0;
      r_cnt        <= '0;
      r_tc         <= '0;
      r_os_phase   <= '0;
      r_active_sel <= baud_sel;
      r_os_tick    <= 1'b0;
      r_bit_tick   <= 1'b0;
      r_sel_ack    <= 1'b0;
    end else begin
      r_run        <= w_run_d;
      r_cnt        <= w_cnt_d;
      r_tc         <= w_tc_d;
      r_os_phase   <= w_phase_d;
      r_active_sel <= w_sel_n;
      r_os_tick    <= w_os_tick_d;
      r_bit_tick   <= w_bit_tick_d;
      r_sel_ack    <= w_apply;
    end
  end

  assign os_tick    = r_os_tick;
  assign bit_tick   = r_bit_tick;
  assign os_phase   = r_os_phase;
  assign active_sel = r_active_sel;
  assign sel_ack    = r_sel_ack;

endmodule
